// File: rtl/channel_wr_scheduler.sv
// Round-robin write-port scheduler: grants one video channel at a time a full AXI write burst.
// Optional macro CH5_PRIORITY_EN lets channel 5 (req bit 4) win every idle arbitration.
module channel_wr_scheduler #(
    parameter int unsigned NUM_CH    = 5,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [NUM_CH-1:0] req,
    input  logic              aw_done,
    input  logic              beat,
    input  logic              b_done,
    output logic [NUM_CH-1:0] gnt,
    output logic [2:0]        gnt_id,
    output logic              aw_start,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned IdxW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
    localparam int unsigned HoldW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [2:0]        gnt_id_q, gnt_id_d;
    logic              aw_start_q, aw_start_d;
    logic              err_q, err_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   cur_q, cur_d;
    logic              prio_q, prio_d;

    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;
    logic [IdxW-1:0]   cand;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_prio;
    logic              timeout;
    logic              done;
    logic              expire;

    // Scan from the channel after the last one served; first requester wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = IdxW'((32'(last_q) + i + 32'd1) % NUM_CH);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef CH5_PRIORITY_EN
    localparam int unsigned PrioIdx = (NUM_CH >= 5) ? 4 : 0;

    always_comb begin
        pick_found = rr_found;
        pick_idx   = rr_idx;
        pick_prio  = 1'b0;
        if (NUM_CH >= 5 && req[IdxW'(PrioIdx)]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(PrioIdx);
            pick_prio  = 1'b1;
        end
    end
`else
    always_comb begin
        pick_found = rr_found;
        pick_idx   = rr_idx;
        pick_prio  = 1'b0;
    end
`endif

    assign timeout = (hold_q == HoldW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        aw_start_d = 1'b0;
        err_d      = 1'b0;
        beat_d     = beat_q;
        hold_d     = (state_q == StIdle) ? '0 : hold_q + HoldW'(1);
        last_d     = last_q;
        cur_d      = cur_q;
        prio_d     = prio_q;
        done       = 1'b0;
        expire     = (state_q != StIdle) && timeout;

        unique case (state_q)
            StIdle: begin
                if (init_done && pick_found) begin
                    state_d         = StAddr;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = 3'(pick_idx) + 3'd1;
                    aw_start_d      = 1'b1;
                    cur_d           = pick_idx;
                    prio_d          = pick_prio;
                end
            end
            StAddr: begin
                if (aw_done) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (beat) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatW'(BURST_LEN - 1)) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                done = b_done;
            end
            default: state_d = StIdle;
        endcase

        // A response in the expiry cycle counts as a normal completion.
        if (done || expire) begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
            beat_d   = '0;
            err_d    = !done;
            if (!done || !prio_q) begin
                last_d = cur_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            aw_start_q <= 1'b0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            hold_q     <= '0;
            last_q     <= IdxW'(NUM_CH - 1);
            cur_q      <= '0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            aw_start_q <= aw_start_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            prio_q     <= prio_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign aw_start    = aw_start_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_channel_wr_scheduler.sv
// Bench for channel_wr_scheduler: vector table, directed corner sequences and a randomized
// run checked against a transaction-level round-robin model.
module tb_channel_wr_scheduler;

    localparam int unsigned NUM_CH    = 5;
    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned TIMEOUT   = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic [4:0]  req = '0;
    logic        aw_done = 1'b0;
    logic        beat = 1'b0;
    logic        b_done = 1'b0;
    logic [4:0]  gnt;
    logic [2:0]  gnt_id;
    logic        aw_start;
    logic        busy;
    logic        err_timeout;

    int n_pass = 0;
    int n_total = 0;

    channel_wr_scheduler #(
        .NUM_CH   (NUM_CH),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .req        (req),
        .aw_done    (aw_done),
        .beat       (beat),
        .b_done     (b_done),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .aw_start   (aw_start),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       init;
        logic [4:0] rq;
        logic       aw;
        logic       bt;
        logic       bd;
        int         rep;
        logic [2:0] id;
        logic       bsy;
        logic       aws;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        aw_done = 1'b0;
        beat = 1'b0;
        b_done = 1'b0;
        req = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Expected winner (0-based) from the requests and the last channel served; -1 if none.
    function automatic int pick(input logic [4:0] r, input int last);
`ifdef CH5_PRIORITY_EN
        if (r[4]) return 4;
`endif
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            int c;
            c = (last + k) % int'(NUM_CH);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic grant_wait(input string tag, input int exp_ch, input int exp_wait);
        int w;
        w = 0;
        do begin
            step();
            w++;
        end while (aw_start !== 1'b1 && w < 200);
        chk({tag, " wait"}, w, exp_wait);
        chk({tag, " gnt_id"}, gnt_id, exp_ch);
        chk({tag, " gnt"}, gnt, 1 << (exp_ch - 1));
        chk({tag, " busy"}, busy, 1);
    endtask

    task automatic complete(input string tag, input int exp_ch);
        aw_done = 1'b1;
        step();
        aw_done = 1'b0;
        chk({tag, " aw_start single"}, aw_start, 0);
        beat = 1'b1;
        repeat (BURST_LEN) step();
        beat = 1'b0;
        chk({tag, " held in resp"}, gnt_id, exp_ch);
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        chk({tag, " gnt cleared"}, gnt, 0);
        chk({tag, " gnt_id cleared"}, gnt_id, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic hold_chk(input int ch);
        req = 5'($urandom_range(0, 31));
        init_done = ($urandom_range(0, 1) != 0);
        step();
        chk("rnd hold gnt_id", gnt_id, ch + 1);
        chk("rnd hold busy", busy, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[6];
        int rot_seq[4];
        int k;
        int seen_busy;
        int seen_aw;
        int last_m;

        // Reset applies without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("reset gnt", gnt, 0);
        chk("reset gnt_id", gnt_id, 0);
        chk("reset aw_start", aw_start, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err_timeout, 0);
        step();
        step();
        rst = 1'b1;

        // init, req, aw_done, beat, b_done, cycles, expected gnt_id, busy, aw_start
        vecs[0]  = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 1'b0,  2, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'b01000, 1'b1, 1'b1, 1'b1,  1, 3'd4, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 1'b1,  3, 3'd4, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'b00000, 1'b1, 1'b0, 1'b0,  1, 3'd4, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'b11111, 1'b0, 1'b1, 1'b1, 15, 3'd4, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'b00000, 1'b1, 1'b0, 1'b0,  2, 3'd4, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 1'b0,  1, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'b00000, 1'b1, 1'b1, 1'b0,  2, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b1,  1, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b0,  2, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'b11111, 1'b0, 1'b0, 1'b0,  1, 3'd5, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 5'b11111, 1'b1, 1'b0, 1'b0,  1, 3'd5, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 5'b00000, 1'b0, 1'b1, 1'b0, 16, 3'd5, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b1,  1, 3'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0};

        for (int v = 0; v < 16; v++) begin
            init_done = vecs[v].init;
            req       = vecs[v].rq;
            aw_done   = vecs[v].aw;
            beat      = vecs[v].bt;
            b_done    = vecs[v].bd;
            repeat (vecs[v].rep) step();
            chk($sformatf("vec%0d gnt_id", v), gnt_id, vecs[v].id);
            chk($sformatf("vec%0d gnt", v), gnt,
                (vecs[v].id == 0) ? 0 : (1 << (vecs[v].id - 1)));
            chk($sformatf("vec%0d busy", v), busy, vecs[v].bsy);
            chk($sformatf("vec%0d aw_start", v), aw_start, vecs[v].aws);
            chk($sformatf("vec%0d err", v), err_timeout, 0);
        end

        // Full rotation with every channel requesting.
`ifdef CH5_PRIORITY_EN
        exp_seq = '{5, 5, 5, 5, 5, 5};
        rot_seq = '{5, 5, 5, 5};
`else
        exp_seq = '{1, 2, 3, 4, 5, 1};
        rot_seq = '{1, 2, 5, 1};
`endif
        do_reset();
        init_done = 1'b1;
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            grant_wait($sformatf("rot%0d", i), exp_seq[i], 1);
            complete($sformatf("rot%0d", i), exp_seq[i]);
        end

        // Single requester: one idle cycle between back-to-back grants.
        req = 5'b00100;
        grant_wait("solo a", 3, 1);
        complete("solo a", 3);
        grant_wait("solo b", 3, 1);
        complete("solo b", 3);

        do_reset();
        init_done = 1'b1;
        req = 5'b10011;
        for (int i = 0; i < 4; i++) begin
            grant_wait($sformatf("mix%0d", i), rot_seq[i], 1);
            complete($sformatf("mix%0d", i), rot_seq[i]);
        end

        // No grants while calibration is pending.
        do_reset();
        init_done = 1'b0;
        req = 5'b11111;
        seen_busy = 0;
        seen_aw = 0;
        repeat (100) begin
            step();
            if (busy) seen_busy++;
            if (aw_start) seen_aw++;
        end
        chk("init low busy cycles", seen_busy, 0);
        chk("init low aw_start cycles", seen_aw, 0);
        init_done = 1'b1;
        grant_wait("init high", 1, 1);
        complete("init high", 1);

        // Forced release when b_done never arrives.
        do_reset();
        init_done = 1'b1;
        req = 5'b00010;
        grant_wait("to grant", 2, 1);
        aw_done = 1'b1;
        step();
        aw_done = 1'b0;
        beat = 1'b1;
        repeat (BURST_LEN) step();
        beat = 1'b0;
        k = BURST_LEN + 1;
        while (err_timeout !== 1'b1 && k < 1100) begin
            step();
            k++;
        end
        chk("timeout cycles", k, TIMEOUT);
        chk("timeout gnt", gnt, 0);
        chk("timeout gnt_id", gnt_id, 0);
        chk("timeout busy", busy, 0);
        req = 5'b00110;
        grant_wait("after timeout", 3, 1);
        chk("timeout pulse single", err_timeout, 0);
        complete("after timeout", 3);

        // b_done in the expiry cycle completes normally.
        req = 5'b01000;
        grant_wait("race", 4, 1);
        req = 5'b00000;
        aw_done = 1'b1;
        step();
        aw_done = 1'b0;
        beat = 1'b1;
        repeat (BURST_LEN) step();
        beat = 1'b0;
        k = BURST_LEN + 1;
        while (k < int'(TIMEOUT) - 1) begin
            step();
            k++;
        end
        chk("race still busy", busy, 1);
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        chk("race err", err_timeout, 0);
        chk("race busy", busy, 0);
        chk("race gnt", gnt, 0);
        step();
        chk("race err later", err_timeout, 0);
        req = 5'b11111;
        grant_wait("after race", 5, 1);

        // Asynchronous reset in mid-burst.
        do_reset();
        init_done = 1'b1;
        req = 5'b00001;
        grant_wait("pre reset", 1, 1);
        aw_done = 1'b1;
        step();
        aw_done = 1'b0;
        beat = 1'b1;
        repeat (7) step();
        beat = 1'b0;
        rst = 1'b0;
        #2;
        chk("async gnt", gnt, 0);
        chk("async gnt_id", gnt_id, 0);
        chk("async aw_start", aw_start, 0);
        chk("async busy", busy, 0);
        chk("async err", err_timeout, 0);
        step();
        step();
        chk("reset no err", err_timeout, 0);
        rst = 1'b1;
        grant_wait("post reset", 1, 1);
        aw_done = 1'b1;
        step();
        aw_done = 1'b0;
        beat = 1'b1;
        repeat (BURST_LEN - 1) step();
        beat = 1'b0;
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        chk("beat restart busy", busy, 1);
        chk("beat restart gnt_id", gnt_id, 1);
        beat = 1'b1;
        step();
        beat = 1'b0;
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        chk("beat restart done", busy, 0);

        // Randomized bursts against the round-robin model.
        do_reset();
        last_m = NUM_CH - 1;
        for (int b = 0; b < 40; b++) begin
            int exp_ch;
            int gap;
            logic [4:0] r;
            logic       i_d;
            exp_ch = -1;
            for (int t = 0; t < 20 && exp_ch < 0; t++) begin
                r = 5'($urandom_range(0, 31));
                i_d = ($urandom_range(0, 3) != 0);
                req = r;
                init_done = i_d;
                step();
                exp_ch = i_d ? pick(r, last_m) : -1;
                if (exp_ch < 0) begin
                    chk("rnd idle busy", busy, 0);
                    chk("rnd idle aw_start", aw_start, 0);
                end else begin
                    chk("rnd grant aw_start", aw_start, 1);
                    chk("rnd grant gnt_id", gnt_id, exp_ch + 1);
                    chk("rnd grant gnt", gnt, 1 << exp_ch);
                end
            end
            if (exp_ch < 0) continue;
            gap = $urandom_range(0, 3);
            repeat (gap) hold_chk(exp_ch);
            aw_done = 1'b1;
            hold_chk(exp_ch);
            aw_done = 1'b0;
            for (int n = 0; n < int'(BURST_LEN); ) begin
                beat = ($urandom_range(0, 1) != 0);
                if (beat) n++;
                hold_chk(exp_ch);
            end
            beat = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) hold_chk(exp_ch);
            b_done = 1'b1;
            step();
            b_done = 1'b0;
            chk("rnd release busy", busy, 0);
            chk("rnd release gnt", gnt, 0);
            chk("rnd release err", err_timeout, 0);
`ifdef CH5_PRIORITY_EN
            if (exp_ch != 4) last_m = exp_ch;
`else
            last_m = exp_ch;
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/channel_wr_scheduler.md
CHANNEL_WR_SCHEDULER -- requirements
Module: channel_wr_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of buffered video channels competing for the DDR write port.
REQ-002 SHALL have parameter BURST_LEN, default 16, data beats per granted burst (AXI awlen = BURST_LEN-1).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles a grant may be held before forced release.
REQ-004 SHALL have port clk  input  1  ddr_clk domain clock; all logic in this single domain.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port init_done  input  1  DDR calibration complete; no grant issued while low.
REQ-007 SHALL have port req  input  NUM_CH  per-channel "burst ready" request; bit 0 is channel 1.
REQ-008 SHALL have port aw_done  input  1  pulse, awvalid & awready accepted.
REQ-009 SHALL have port beat  input  1  pulse, wvalid & wready accepted.
REQ-010 SHALL have port b_done  input  1  pulse, write response accepted.
REQ-011 SHALL have port gnt  output  NUM_CH  one-hot grant, held from grant to release.
REQ-012 SHALL have port gnt_id  output  3  binary index of granted channel, 0 when idle.
REQ-013 SHALL have port aw_start  output  1  single-cycle pulse requesting an AXI address phase.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port err_timeout  output  1  single-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA, RESP.
REQ-017 SHALL in IDLE, with init_done=1 and req!=0, select one requester and enter ADDR on the next edge, registering gnt/gnt_id and pulsing aw_start for exactly that first ADDR cycle.
REQ-018 SHALL select round-robin: search starts at index (last_granted+1) mod NUM_CH; after reset last_granted = NUM_CH-1, so channel 1 (bit 0) wins first.
REQ-019 SHALL move ADDR->DATA on aw_done; aw_done in any other state is ignored.
REQ-020 SHALL count beat pulses in DATA with a counter cleared on entry; on the BURST_LEN-th beat move to RESP; beats outside DATA are ignored.
REQ-021 SHALL move RESP->IDLE on b_done, clearing gnt to 0 and gnt_id to 0 and updating last_granted at that edge.
REQ-022 SHALL spend at least one IDLE cycle between consecutive grants; req sampled only in IDLE.
REQ-023 SHALL keep the grant even if the granted req bit deasserts mid-burst.
REQ-024 SHALL run a hold counter cleared on leaving IDLE; if it reaches TIMEOUT outside IDLE, return to IDLE, clear gnt, pulse err_timeout, and advance last_granted past the offending channel.
REQ-025 SHALL let b_done win over timeout when both occur in the same cycle (no err_timeout pulse).
REQ-026 SHALL treat init_done falling while busy as no event: the current burst completes; no new grant until init_done returns high.
REQ-027 SHALL mask req bits at index >= NUM_CH; counters SHALL be wide enough for BURST_LEN and TIMEOUT without wrap.

Reset
REQ-028 SHALL on rst low immediately force state IDLE, gnt=0, gnt_id=0, aw_start=0, busy=0, err_timeout=0, counters 0, last_granted=NUM_CH-1, independent of clk.
REQ-029 SHALL abandon a burst in progress on mid-operation reset without emitting err_timeout.

Configuration
REQ-030 SHALL support macro CH5_PRIORITY_EN: when defined, channel 5 (bit 4, main 9/16 view) wins any IDLE arbitration in which it requests, without updating last_granted; when undefined, all channels are pure round-robin.

Verification
REQ-031 SHALL test: reset release, init_done=1, req=5'b11111, full handshakes each burst -> grants in order ch1,ch2,ch3,ch4,ch5,ch1 (macro undefined).
REQ-032 SHALL test: req=5'b00100 -> aw_start pulses one cycle after IDLE sample; 16 beats + b_done -> gnt clears; exactly one IDLE cycle before next grant.
REQ-033 SHALL test: grant to ch2, withhold b_done 1023 cycles -> err_timeout pulse, gnt=0, next grant goes to ch3 when req=5'b00110.
REQ-034 SHALL test: CH5_PRIORITY_EN defined, req=5'b10011 constant -> ch5 granted every burst; undefined -> ch1,ch2,ch5 rotation.
REQ-035 SHALL test: rst low during DATA at beat 7 -> all outputs 0 asynchronously; after release, req=5'b00001 granted with beat count restarting at 0.
REQ-036 SHALL test: init_done=0 with req=5'b11111 for 100 cycles -> busy stays 0, no aw_start.
